// File: rtl/lvds_frame_tx.sv
// lvds_frame_tx
//   Store-and-forward byte framer for the LVDS transmit path. Byte frames
//   arrive on the system side (sof/vld/eof with a length sampled at sof),
//   are buffered and checked, and malformed frames are discarded. Good
//   frames are serialised onto a LANES-wide bus as SYNC(16b) + LEN(16b) +
//   payload, MSB first, followed by a programmable idle gap.
//
// Ports
//   clk_100m    system clock (single domain)
//   rst         asynchronous, active-high reset
//   din_sof     first byte of a frame (qualified by din_vld)
//   din_vld     input byte valid
//   din_eof     last byte of a frame (qualified by din_vld)
//   din         payload byte
//   din_len     frame length in bytes, sampled with din_sof
//   din_rdy     length queue not full; a new frame may start only when high
//   dout        lane data, MSB first
//   dout_vld    lane data valid during SYNC, LEN and DATA
//   dout_sof    one-cycle pulse on the first SYNC cycle
//   busy        transmit FSM not idle
//   frame_cnt   frames fully transmitted
//   drop_cnt    frames discarded on input
module lvds_frame_tx #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned MAX_LEN   = 2048,
  parameter int unsigned LQ_DEPTH  = 4,
  parameter logic [15:0] SYNC_WORD = 16'hEB90,
  parameter int unsigned IDLE_GAP  = 8
) (
  input  logic             clk_100m,
  input  logic             rst,
  input  logic             din_sof,
  input  logic             din_vld,
  input  logic             din_eof,
  input  logic [7:0]       din,
  input  logic [15:0]      din_len,
  output logic             din_rdy,
  output logic [LANES-1:0] dout,
  output logic             dout_vld,
  output logic             dout_sof,
  output logic             busy,
  output logic [31:0]      frame_cnt,
  output logic [31:0]      drop_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned QW   = $clog2(LQ_DEPTH);
  localparam int unsigned HCYC = 16 / LANES;
  localparam int unsigned BCYC = 8 / LANES;

  localparam logic [PW-1:0] BUF_FULL  = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [QW:0]   LQ_FULL   = (QW+1)'(LQ_DEPTH);
  localparam logic [QW:0]   LQ_ONE    = (QW+1)'(1);
  localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0]   HCYC_END  = 16'(HCYC - 1);
  localparam logic [15:0]   BCYC_END  = 16'(BCYC - 1);
  localparam logic [15:0]   GAP_END   = 16'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_DATA,
    ST_GAP
  } state_t;

  // Storage (no reset: contents are only meaningful behind the pointers)
  logic [7:0]  mem    [DEPTH];
  logic [15:0] lq_mem [LQ_DEPTH];
  logic [7:0]  rdata_q;

  // Input side
  logic          open_q, open_d;
  logic [15:0]   ilen_q, ilen_d;
  logic [15:0]   icnt_q, icnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cm_q, cm_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          lq_push;
  logic [15:0]   lq_wdata;
  logic [1:0]    drop_inc;

  // Length queue
  logic [QW:0]   lq_wr_q, lq_wr_d;
  logic [QW:0]   lq_rd_q, lq_rd_d;
  logic          lq_full, lq_empty;

  // Output side
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   sh_q, sh_d;
  logic [15:0]   txlen_q, txlen_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic          rd_en;
  logic          lq_pop;
  logic [7:0]    byte_sh;

  assign lq_full  = (lq_wr_q - lq_rd_q) == LQ_FULL;
  assign lq_empty = (lq_wr_q == lq_rd_q);
  assign din_rdy  = ~lq_full;

  // Input framing: bytes of the open frame land at wr; only an eof with a
  // matching count moves cm forward and publishes the length. Any drop rolls
  // wr back to cm so the uncommitted bytes are simply overwritten later.
  always_comb begin
    open_d    = open_q;
    ilen_d    = ilen_q;
    icnt_d    = icnt_q;
    wr_d      = wr_q;
    cm_d      = cm_q;
    mem_we    = 1'b0;
    mem_waddr = wr_q[AW-1:0];
    lq_push   = 1'b0;
    lq_wdata  = ilen_q;
    drop_inc  = 2'd0;

    if (din_vld) begin
      if (din_sof) begin
        open_d = 1'b0;
        wr_d   = cm_q;
        if (open_q) drop_inc = drop_inc + 2'd1;
        if (din_len == '0 || din_len > MAX_LEN_W || !din_rdy ||
            (cm_q - rd_q) == BUF_FULL) begin
          drop_inc = drop_inc + 2'd1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = cm_q[AW-1:0];
          wr_d      = cm_q + PTR_ONE;
          ilen_d    = din_len;
          icnt_d    = 16'd1;
          open_d    = 1'b1;
          if (din_eof) begin
            open_d = 1'b0;
            if (din_len == 16'd1) begin
              cm_d     = cm_q + PTR_ONE;
              lq_push  = 1'b1;
              lq_wdata = din_len;
            end else begin
              drop_inc = drop_inc + 2'd1;
              wr_d     = cm_q;
            end
          end
        end
      end else if (open_q) begin
        // A byte beyond the latched length can never end in a matching eof,
        // so the frame is discarded as soon as it overruns.
        if (icnt_q == ilen_q || (wr_q - rd_q) == BUF_FULL) begin
          drop_inc = drop_inc + 2'd1;
          open_d   = 1'b0;
          wr_d     = cm_q;
        end else begin
          mem_we = 1'b1;
          wr_d   = wr_q + PTR_ONE;
          icnt_d = icnt_q + 16'd1;
          if (din_eof) begin
            open_d = 1'b0;
            if (icnt_q + 16'd1 == ilen_q) begin
              cm_d    = wr_q + PTR_ONE;
              lq_push = 1'b1;
            end else begin
              drop_inc = drop_inc + 2'd1;
              wr_d     = cm_q;
            end
          end
        end
      end
    end

    drop_cnt_d = drop_cnt_q + {30'd0, drop_inc};
    lq_wr_d    = lq_push ? lq_wr_q + LQ_ONE : lq_wr_q;
  end

  // Transmit FSM. The first payload byte is read on the last LEN cycle and
  // each following byte on the last lane slot of the previous one, so the
  // 1-cycle buffer latency never opens a bubble in DATA.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    txlen_d     = txlen_q;
    bcnt_d      = bcnt_q;
    rd_d        = rd_q;
    frame_cnt_d = frame_cnt_q;
    rd_en       = 1'b0;
    lq_pop      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!lq_empty) begin
          lq_pop  = 1'b1;
          txlen_d = lq_mem[lq_rd_q[QW-1:0]];
          sh_d    = SYNC_WORD;
          cnt_d   = '0;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        sh_d  = sh_q << LANES;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HCYC_END) begin
          sh_d    = txlen_q;
          cnt_d   = '0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        sh_d  = sh_q << LANES;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HCYC_END) begin
          rd_en   = 1'b1;
          cnt_d   = '0;
          bcnt_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BCYC_END) begin
          cnt_d = '0;
          if (bcnt_q == txlen_q - 16'd1) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            state_d     = ST_GAP;
          end else begin
            rd_en  = 1'b1;
            bcnt_d = bcnt_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_en) rd_d = rd_q + PTR_ONE;
    lq_rd_d = lq_pop ? lq_rd_q + LQ_ONE : lq_rd_q;
  end

  // Outputs decode straight from registered state, so an asserted reset
  // forces them low without waiting for a clock edge.
  always_comb begin
    dout     = '0;
    dout_vld = 1'b0;
    dout_sof = 1'b0;
    byte_sh  = rdata_q << (32'(cnt_q) * LANES);
    unique case (state_q)
      ST_SYNC: begin
        dout_vld = 1'b1;
        dout_sof = (cnt_q == '0);
        dout     = sh_q[15 -: LANES];
      end
      ST_LEN: begin
        dout_vld = 1'b1;
        dout     = sh_q[15 -: LANES];
      end
      ST_DATA: begin
        dout_vld = 1'b1;
        dout     = byte_sh[7 -: LANES];
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  always_ff @(posedge clk_100m) begin
    if (mem_we)  mem[mem_waddr] <= din;
    if (rd_en)   rdata_q <= mem[rd_q[AW-1:0]];
    if (lq_push) lq_mem[lq_wr_q[QW-1:0]] <= lq_wdata;
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      open_q      <= 1'b0;
      ilen_q      <= '0;
      icnt_q      <= '0;
      wr_q        <= '0;
      cm_q        <= '0;
      drop_cnt_q  <= '0;
      lq_wr_q     <= '0;
      lq_rd_q     <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      txlen_q     <= '0;
      bcnt_q      <= '0;
      rd_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      open_q      <= open_d;
      ilen_q      <= ilen_d;
      icnt_q      <= icnt_d;
      wr_q        <= wr_d;
      cm_q        <= cm_d;
      drop_cnt_q  <= drop_cnt_d;
      lq_wr_q     <= lq_wr_d;
      lq_rd_q     <= lq_rd_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      txlen_q     <= txlen_d;
      bcnt_q      <= bcnt_d;
      rd_q        <= rd_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_lvds_frame_tx.sv
module tb_lvds_frame_tx;

  localparam int IGAP = 8;
  localparam int MAXL = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        sof, vld, xvld, eof;
  logic [7:0]  din;
  logic [15:0] len;

  logic        rdy, dv, ds, busy;
  logic [3:0]  dout;
  logic [31:0] fcnt, dcnt;

  logic        d1_rdy, d1_vld, d1_sof, d1_busy;
  logic [0:0]  d1_dout;
  logic [31:0] d1_fcnt, d1_dcnt;
  logic        d8_rdy, d8_vld, d8_sof, d8_busy;
  logic [7:0]  d8_dout;
  logic [31:0] d8_fcnt, d8_dcnt;

  int checks = 0;
  int errors = 0;

  bit act[$];
  bit expq[$];
  int runs[$];
  int sof_bad = 0, idle_nz = 0;
  int min_gap = 1000000, gap_run = 0, vld_run = 0;
  bit prev_vld = 0, started = 0;
  bit b1[$];
  bit b8[$];
  int n1 = 0, n8 = 0;

  logic [7:0] pay [64];
  int exp_drop = 0, exp_frames = 0;

  always #5 clk = ~clk;

  lvds_frame_tx #(.LANES(4), .IDLE_GAP(IGAP), .MAX_LEN(MAXL)) dut (
    .clk_100m(clk), .rst(rst), .din_sof(sof), .din_vld(vld), .din_eof(eof),
    .din(din), .din_len(len), .din_rdy(rdy), .dout(dout), .dout_vld(dv),
    .dout_sof(ds), .busy(busy), .frame_cnt(fcnt), .drop_cnt(dcnt));

  lvds_frame_tx #(.LANES(1)) dut1 (
    .clk_100m(clk), .rst(rst), .din_sof(sof), .din_vld(xvld), .din_eof(eof),
    .din(din), .din_len(len), .din_rdy(d1_rdy), .dout(d1_dout), .dout_vld(d1_vld),
    .dout_sof(d1_sof), .busy(d1_busy), .frame_cnt(d1_fcnt), .drop_cnt(d1_dcnt));

  lvds_frame_tx #(.LANES(8)) dut8 (
    .clk_100m(clk), .rst(rst), .din_sof(sof), .din_vld(xvld), .din_eof(eof),
    .din(din), .din_len(len), .din_rdy(d8_rdy), .dout(d8_dout), .dout_vld(d8_vld),
    .dout_sof(d8_sof), .busy(d8_busy), .frame_cnt(d8_fcnt), .drop_cnt(d8_dcnt));

  // Output monitors: bit streams, vld run lengths, gaps, sof placement.
  always @(negedge clk) begin
    if (dv) begin
      for (int i = 3; i >= 0; i--) act.push_back(dout[i]);
      if (!prev_vld) begin
        if (started && gap_run < min_gap) min_gap = gap_run;
        if (ds !== 1'b1) sof_bad++;
      end else if (ds !== 1'b0) sof_bad++;
      vld_run++;
    end else begin
      if (prev_vld) begin
        runs.push_back(vld_run);
        vld_run = 0;
        gap_run = 0;
        started = 1;
      end
      gap_run++;
      if (dout !== 4'd0 || ds !== 1'b0) idle_nz++;
    end
    prev_vld = dv;
  end

  always @(negedge clk) begin
    if (d1_vld) begin
      b1.push_back(d1_dout[0]);
      n1++;
    end
    if (d8_vld) begin
      for (int i = 7; i >= 0; i--) b8.push_back(d8_dout[i]);
      n8++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    act.delete();
    expq.delete();
    runs.delete();
    min_gap = 1000000;
    started = 0;
    gap_run = 0;
  endtask

  // Reference: a good frame appears on the wire as SYNC, LEN, bytes, MSB first.
  task automatic model_add(input logic [15:0] l);
    logic [15:0] w;
    logic [7:0]  b;
    w = 16'hEB90;
    for (int i = 15; i >= 0; i--) expq.push_back(w[i]);
    for (int i = 15; i >= 0; i--) expq.push_back(l[i]);
    for (int k = 0; k < int'(l); k++) begin
      b = pay[k];
      for (int i = 7; i >= 0; i--) expq.push_back(b[i]);
    end
  endtask

  function automatic int stream_mis();
    int m;
    m = (act.size() > expq.size()) ? act.size() - expq.size() : expq.size() - act.size();
    for (int i = 0; i < act.size() && i < expq.size(); i++)
      if (act[i] !== expq[i]) m++;
    return m;
  endfunction

  task automatic send(input logic [15:0] lenf, input int n, input bit do_eof,
                      input bit wait_rdy, input bit ext, output bit to);
    int k;
    to = 0;
    if (wait_rdy) begin
      k = 0;
      while (rdy !== 1'b1 && k < 2000) begin
        @(posedge clk); #1;
        k++;
      end
      if (rdy !== 1'b1) to = 1;
    end
    for (int i = 0; i < n; i++) begin
      sof = (i == 0);
      eof = do_eof && (i == n - 1);
      din = pay[i];
      len = lenf;
      if (ext) xvld = 1'b1; else vld = 1'b1;
      @(posedge clk); #1;
    end
    vld = 0; xvld = 0; sof = 0; eof = 0;
  endtask

  task automatic drain(output bit to);
    int k;
    k = 0;
    while ((act.size() < expq.size() || busy !== 1'b0) && k < 20000) begin
      @(posedge clk); #1;
      k++;
    end
    to = (k >= 20000);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sof = 0; vld = 0; xvld = 0; eof = 0; din = '0; len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    checks++; if (dout !== 4'd0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", dv); end
    checks++; if (ds !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", ds); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fcnt !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", fcnt); end
    checks++; if (dcnt !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", dcnt); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    @(posedge clk); #1;
    clear_mon();
  endtask

  task automatic test_basic();
    bit to, to2;
    logic [3:0] exp1 [14];
    logic [3:0] nib;
    int bad;
    exp1 = '{4'hE, 4'hB, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3};
    clear_mon();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send(16'd3, 3, 1, 1, 0, to);
    model_add(16'd3); exp_frames++;
    drain(to2);
    checks++; if (to || to2) begin errors++; $display("FAIL basic_timeout: got 1 want 0"); end
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (act.size() >= 4 * i + 4) nib = {act[4*i], act[4*i+1], act[4*i+2], act[4*i+3]};
      else nib = 4'hx;
      if (nib !== exp1[i]) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_nibbles: %0d wrong nibbles want 0", bad); end
    checks++; if (runs.size() !== 1 || runs[0] !== 14) begin
      errors++; $display("FAIL basic_vld_cycles: got %0d runs first %0d want 1 run of 14", runs.size(), (runs.size() > 0) ? runs[0] : -1);
    end
    checks++; if (fcnt !== 32'(exp_frames)) begin errors++; $display("FAIL basic_frame_cnt: got %0d want %0d", fcnt, exp_frames); end
  endtask

  task automatic test_bad_count();
    bit to, to2;
    int m;
    clear_mon();
    for (int i = 0; i < 4; i++) pay[i] = 8'(i + 8'h40);
    send(16'd4, 3, 1, 1, 0, to);
    exp_drop++;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (dcnt !== 32'(exp_drop)) begin errors++; $display("FAIL short_drop_cnt: got %0d want %0d", dcnt, exp_drop); end
    checks++; if (act.size() !== 0) begin errors++; $display("FAIL short_no_output: got %0d bits want 0", act.size()); end
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    send(16'd5, 5, 1, 1, 0, to2);
    model_add(16'd5); exp_frames++;
    drain(to);
    m = stream_mis();
    checks++; if (m !== 0 || to || to2) begin errors++; $display("FAIL short_next_frame: %0d bit errors want 0", m); end
    checks++; if (fcnt !== 32'(exp_frames)) begin errors++; $display("FAIL short_frame_cnt: got %0d want %0d", fcnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    bit to, tos;
    int m;
    clear_mon();
    tos = 0;
    for (int f = 0; f < 5; f++) begin
      pay[0] = 8'($urandom); pay[1] = 8'($urandom);
      send(16'd2, 2, 1, 1, 0, to);
      tos |= to;
      model_add(16'd2); exp_frames++;
    end
    // First frame is already in flight, four more fill the length queue.
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_full: got %b want 0", rdy); end
    send(16'd2, 2, 1, 0, 0, to);
    exp_drop++;
    @(posedge clk); #1;
    checks++; if (dcnt !== 32'(exp_drop)) begin errors++; $display("FAIL b2b_drop_when_full: got %0d want %0d", dcnt, exp_drop); end
    drain(to);
    m = stream_mis();
    checks++; if (m !== 0 || to || tos) begin errors++; $display("FAIL b2b_stream: %0d bit errors want 0", m); end
    checks++; if (runs.size() !== 5) begin errors++; $display("FAIL b2b_frames_seen: got %0d want 5", runs.size()); end
    checks++; if (!(min_gap >= IGAP)) begin errors++; $display("FAIL b2b_gap: got %0d want >= %0d", min_gap, IGAP); end
    checks++; if (fcnt !== 32'(exp_frames)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", fcnt, exp_frames); end
  endtask

  task automatic test_len_limits();
    bit to, t1, t2, t3;
    int m;
    clear_mon();
    pay[0] = 8'h01; pay[1] = 8'h02;
    send(16'(MAXL + 1), 2, 1, 1, 0, t1);
    send(16'd0, 1, 1, 1, 0, t2);
    exp_drop += 2;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dcnt !== 32'(exp_drop)) begin errors++; $display("FAIL limits_drop_cnt: got %0d want %0d", dcnt, exp_drop); end
    pay[0] = 8'h5C;
    send(16'd1, 1, 1, 1, 0, t3);
    model_add(16'd1); exp_frames++;
    drain(to);
    m = stream_mis();
    checks++; if (m !== 0 || to || t1 || t2 || t3) begin errors++; $display("FAIL limits_single_byte: %0d bit errors want 0", m); end
    checks++; if (fcnt !== 32'(exp_frames)) begin errors++; $display("FAIL limits_frame_cnt: got %0d want %0d", fcnt, exp_frames); end
  endtask

  task automatic test_lane_widths();
    bit to;
    int k, m1, m8;
    clear_mon();
    b1.delete(); b8.delete(); n1 = 0; n8 = 0;
    pay[0] = 8'hA5;
    send(16'd1, 1, 1, 1, 1, to);
    model_add(16'd1);
    k = 0;
    while ((n1 < 40 || d1_busy !== 1'b0 || d8_busy !== 1'b0) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (5) @(posedge clk);
    #1;
    m1 = 0; m8 = 0;
    for (int i = 0; i < expq.size(); i++) begin
      if (i >= b1.size() || b1[i] !== expq[i]) m1++;
      if (i >= b8.size() || b8[i] !== expq[i]) m8++;
    end
    checks++; if (n1 !== 40 || k >= 500 || to) begin errors++; $display("FAIL lanes1_vld_cycles: got %0d want 40", n1); end
    checks++; if (n8 !== 5) begin errors++; $display("FAIL lanes8_vld_cycles: got %0d want 5", n8); end
    checks++; if (m1 !== 0) begin errors++; $display("FAIL lanes1_bits: %0d bit errors want 0", m1); end
    checks++; if (m8 !== 0) begin errors++; $display("FAIL lanes8_bits: %0d bit errors want 0", m8); end
    checks++; if (d1_fcnt !== 32'd1 || d8_fcnt !== 32'd1) begin
      errors++; $display("FAIL lanes_frame_cnt: got %0d/%0d want 1/1", d1_fcnt, d8_fcnt);
    end
    clear_mon();
  endtask

  task automatic test_random();
    bit to, tos;
    int kind, n, m, l;
    clear_mon();
    tos = 0;
    // Stray bytes with no frame open are ignored.
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      vld = 1; din = pay[i]; len = 16'd3;
      @(posedge clk); #1;
    end
    vld = 0;
    for (int f = 0; f < 16; f++) begin
      kind = $urandom_range(0, 5);
      n = $urandom_range(2, 24);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      case (kind)
        0: begin send(16'(n), n, 1, 1, 0, to); model_add(16'(n)); exp_frames++; end
        1: begin l = n + 1 + $urandom_range(0, 3); send(16'(l), n, 1, 1, 0, to); exp_drop++; end
        2: begin l = MAXL + 1 + $urandom_range(0, 100); send(16'(l), n, 1, 1, 0, to); exp_drop++; end
        3: begin send(16'd0, n, 1, 1, 0, to); exp_drop++; end
        4: begin
          send(16'(n + 5), n, 0, 1, 0, to);
          tos |= to;
          exp_drop++;
          n = $urandom_range(1, 24);
          for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
          send(16'(n), n, 1, 1, 0, to);
          model_add(16'(n)); exp_frames++;
        end
        default: begin send(16'(n - 1), n, 1, 1, 0, to); exp_drop++; end
      endcase
      tos |= to;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain(to);
    m = stream_mis();
    checks++; if (m !== 0 || to || tos) begin errors++; $display("FAIL random_stream: %0d bit errors want 0", m); end
    checks++; if (dcnt !== 32'(exp_drop)) begin errors++; $display("FAIL random_drop_cnt: got %0d want %0d", dcnt, exp_drop); end
    checks++; if (fcnt !== 32'(exp_frames)) begin errors++; $display("FAIL random_frame_cnt: got %0d want %0d", fcnt, exp_frames); end
    checks++; if (sof_bad !== 0) begin errors++; $display("FAIL sof_placement: got %0d bad cycles want 0", sof_bad); end
    checks++; if (idle_nz !== 0) begin errors++; $display("FAIL idle_dout_zero: got %0d bad cycles want 0", idle_nz); end
    checks++; if (started && !(min_gap >= IGAP)) begin errors++; $display("FAIL random_gap: got %0d want >= %0d", min_gap, IGAP); end
  endtask

  task automatic test_reset_mid();
    bit to, to2;
    int k, m;
    clear_mon();
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    send(16'd20, 20, 1, 1, 0, to);
    k = 0;
    while (act.size() <= 48 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (k >= 500 || to) begin errors++; $display("FAIL midrst_reach_data: got %0d bits want > 48", act.size()); end
    @(posedge clk);
    #3 rst = 1;
    #1;
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL midrst_async_vld: got %b want 0", dv); end
    checks++; if (ds !== 1'b0 || dout !== 4'd0) begin errors++; $display("FAIL midrst_async_dout: got sof %b dout %h want 0 0", ds, dout); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_drop = 0; exp_frames = 0;
    @(posedge clk); #1;
    checks++; if (fcnt !== 32'd0 || dcnt !== 32'd0) begin errors++; $display("FAIL midrst_counters: got %0d/%0d want 0/0", fcnt, dcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    clear_mon();
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    send(16'd6, 6, 1, 1, 0, to);
    model_add(16'd6); exp_frames++;
    drain(to2);
    m = stream_mis();
    checks++; if (m !== 0 || to || to2) begin errors++; $display("FAIL midrst_next_frame: %0d bit errors want 0", m); end
    checks++; if (fcnt !== 32'(exp_frames)) begin errors++; $display("FAIL midrst_frame_cnt: got %0d want %0d", fcnt, exp_frames); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_count();
    test_back_to_back();
    test_len_limits();
    test_lane_widths();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
